axi_mem_responder: RTL
======================

# axi_mem_responder

AXI4 slave that terminates the external-memory AXI port and backs it with on-chip synchronous RAM. It is the responder for the AXI master port of the external-memory subsystem, which comprises the L2 cache and its AXI back end. It stands in for the MIG/DDR controller in simulation and in DDR-less FPGA builds. It serves one transaction at a time, with full-throughput INCR bursts, byte strobes and error responses for unsupported requests.

## Interface
- `ADDR_W`, default 30: AXI address width; matches `DDR_ADDR_W`.
- `DATA_W`, default 256: AXI data width; matches `MIG_BUS_W`; power of two, ≥32.
- `MEM_ADDR_W`, default 14: log2 of the RAM depth in `DATA_W` words.
- `clk` in 1: the single clock for the block.
- `rst` in 1: reset; asynchronous, active-low.
- `axi_awid` in 1: write ID, captured with the address.
- `axi_awaddr` in `ADDR_W`: write start byte address.
- `axi_awlen` in 8: write burst beats minus one.
- `axi_awsize` in 3: write beat size.
- `axi_awburst` in 2: write burst type.
- `axi_awlock`/`awcache`/`awprot`/`awqos` in 1/4/3/4: ignored.
- `axi_awvalid` in 1, `axi_awready` out 1: AW handshake.
- `axi_wdata` in `DATA_W`: write data.
- `axi_wstrb` in `DATA_W/8`: write byte strobes.
- `axi_wlast` in 1: last write beat.
- `axi_wvalid` in 1, `axi_wready` out 1: W handshake.
- `axi_bid` out 1: write response ID.
- `axi_bresp` out 2: write response.
- `axi_bvalid` out 1, `axi_bready` in 1: B handshake.
- `axi_arid` in 1: read ID, captured with the address.
- `axi_araddr` in `ADDR_W`: read start byte address.
- `axi_arlen` in 8: read burst beats minus one.
- `axi_arsize` in 3: read beat size.
- `axi_arburst` in 2: read burst type.
- `axi_arlock`/`arcache`/`arprot`/`arqos` in 1/4/3/4: ignored.
- `axi_arvalid` in 1, `axi_arready` out 1: AR handshake.
- `axi_rid` out 1: read data ID.
- `axi_rdata` out `DATA_W`: read data.
- `axi_rresp` out 2: read response.
- `axi_rlast` out 1: last read beat.
- `axi_rvalid` out 1, `axi_rready` in 1: R handshake.

## Operation
- **States:**
  - IDLE: `awready` = `arready` = 1, but only one of them is granted per cycle.
  - WRITE: accepting W beats.
  - WRESP: `bvalid` held.
  - READ: issuing RAM reads and draining R beats.
- **IDLE arbitration:**
  - If `awvalid` and `arvalid` are asserted in the same cycle, round-robin selects the winner; the priority bit flips to the other channel after each grant.
  - After reset the priority bit favours write.
  - The losing ready is driven 0 in that cycle.
- **Word index** = `addr[MEM_ADDR_W+OFF-1:OFF]`, where OFF = log2(`DATA_W/8`). Upper address bits are ignored, so the RAM aliases.
- **Index increment:** +1 per beat, wrapping modulo 2^`MEM_ADDR_W`.
- **Error flag:** set at the address handshake when burst ≠ INCR or size ≠ OFF. When the flag is set:
  - the burst is still fully consumed or produced;
  - RAM writes are suppressed;
  - read data is 0;
  - the response is SLVERR (2'b10); otherwise it is OKAY (2'b00).
- **WRITE:**
  - `wready` = 1.
  - Each accepted beat writes the RAM with a per-byte `wstrb` mask.
  - A beat counter counts to `awlen`; the burst ends on the counter, not on `wlast`.
  - A `wlast` that does not match (counter == `awlen`) also sets SLVERR.
- **WRESP:** `bid` = the captured ID; `bvalid` is held until `bready`, then the state returns to IDLE.
- **READ:**
  - RAM read addresses are issued into a 2-entry skid buffer; a read is issued only when a free slot is guaranteed.
  - `rlast` is set on beat `arlen`.
  - The state returns to IDLE when the last beat's R handshake completes.
- **Reset (any cycle, including mid-burst):** all state clears, the state returns to IDLE and all valids drop. RAM contents are not reset.

## Timing
- **Reset values:**
  - `awready` = `arready` = 1 (IDLE).
  - `wready` = `bvalid` = `rvalid` = `rlast` = 0.
  - `bresp` = `rresp` = 0; `bid` = `rid` = 0; `rdata` = 0.
- **Write:**
  - AW handshake at cycle 0; `wready` = 1 from cycle 1.
  - Beats are accepted back-to-back.
  - `bvalid` asserts the cycle after the last beat.
- **Read:**
  - AR handshake at cycle 0; first `rvalid` at cycle 2.
  - With `rready` held at 1, one beat per cycle.
  - When `rready` deasserts, `rdata`/`rlast`/`rresp` stay stable, no beat is lost or duplicated, and full rate resumes on the next cycle `rready` is 1.
- **Return to IDLE:** the block is in IDLE, and `awready`/`arready` are 1, the cycle after the B handshake or the final R handshake.
- **Minimum length:** a 1-beat burst (`len` = 0) is legal.
- **Maximum length:** a 256-beat burst (`len` = 255) is legal and wraps the index correctly.

## Structure
- **Shared package:**
  - AXI BURST_INCR, RESP_OKAY and RESP_SLVERR constants.
  - State encoding localparams.
  - OFF = $clog2(`DATA_W/8`).
- **Sub-modules:**
  - `axi_resp_skid_buf`: 2-entry valid/ready buffer carrying {rdata, rresp, rlast}, with an occupancy output used for read issue.
  - RAM: the existing byte-enable synchronous single-port RAM primitive.

## Test plan
- **Write then read:** write 4 beats at 0x100 (len=3) with data k+1 and full strobes, then read 0x100 len=3 → B OKAY; rdata 1, 2, 3, 4; `rlast` on beat 3; first `rvalid` 2 cycles after AR.
- **Byte strobes:** write 0xFF…FF, then write 0 with `wstrb` = 0x1 → readback low byte 0x00, all other bytes 0xFF.
- **Backpressure:** read len=7 with `rready` toggling 1,0,0,1… → exactly 8 beats in order, data stable while stalled, no duplicates.
- **Simultaneous requests:** AW and AR both valid at reset release → write granted first, read next; repeat → grants alternate.
- **Errors:** `awburst` = WRAP → SLVERR and RAM unchanged; `arsize` = 2 → 4 beats of zero data with SLVERR; a write with early `wlast` → SLVERR.
- **Reset and wrap:** `rst` asserted mid-read → all valids 0 immediately, IDLE after release. A write of len=1 at the last RAM word wraps its second beat to word 0.

Source files
------------

// File: rtl/axi_mem_responder_pkg.sv
// axi_mem_responder_pkg: AXI constants, FSM encoding and address helpers for the memory responder
package axi_mem_responder_pkg;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_WRESP = 2'd2;
  localparam logic [1:0] ST_READ = 2'd3;
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    WRITE = ST_WRITE,
    WRESP = ST_WRESP,
    READ = ST_READ
  } state_t;
  function automatic int off_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction
endpackage

// File: rtl/axi_resp_skid_buf.sv
// axi_resp_skid_buf: 2-entry valid/ready buffer for read responses, exposing occupancy for issue control
module axi_resp_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);
  logic [W-1:0] d0, d1;
  logic pop;
  logic [1:0] kept;
  assign out_valid = count != 2'd0;
  assign out_data = out_valid ? d0 : '0;
  assign pop = out_valid & out_ready;
  assign kept = count - {1'b0, pop};
  // the issuer guarantees a free slot, so a push never meets a full buffer
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      count <= '0;
      d0 <= '0;
      d1 <= '0;
    end else begin
      count <= kept + {1'b0, in_valid};
      if (pop) d0 <= d1;
      if (in_valid && kept == 2'd0) d0 <= in_data;
      if (in_valid && kept == 2'd1) d1 <= in_data;
    end
endmodule

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: single-transaction AXI4 slave backed by on-chip byte-enable RAM
module axi_mem_responder
  import axi_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 256,
  parameter int MEM_ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axi_awid,
  input  logic [ADDR_W-1:0] axi_awaddr,
  input  logic [7:0]        axi_awlen,
  input  logic [2:0]        axi_awsize,
  input  logic [1:0]        axi_awburst,
  input  logic              axi_awlock,
  input  logic [3:0]        axi_awcache,
  input  logic [2:0]        axi_awprot,
  input  logic [3:0]        axi_awqos,
  input  logic              axi_awvalid,
  output logic              axi_awready,
  input  logic [DATA_W-1:0] axi_wdata,
  input  logic [DATA_W/8-1:0] axi_wstrb,
  input  logic              axi_wlast,
  input  logic              axi_wvalid,
  output logic              axi_wready,
  output logic              axi_bid,
  output logic [1:0]        axi_bresp,
  output logic              axi_bvalid,
  input  logic              axi_bready,
  input  logic              axi_arid,
  input  logic [ADDR_W-1:0] axi_araddr,
  input  logic [7:0]        axi_arlen,
  input  logic [2:0]        axi_arsize,
  input  logic [1:0]        axi_arburst,
  input  logic              axi_arlock,
  input  logic [3:0]        axi_arcache,
  input  logic [2:0]        axi_arprot,
  input  logic [3:0]        axi_arqos,
  input  logic              axi_arvalid,
  output logic              axi_arready,
  output logic              axi_rid,
  output logic [DATA_W-1:0] axi_rdata,
  output logic [1:0]        axi_rresp,
  output logic              axi_rlast,
  output logic              axi_rvalid,
  input  logic              axi_rready
);
  localparam int OFF = off_bits(DATA_W);
  localparam int SW = DATA_W / 8;
  state_t state, state_nx;
  logic prio_rd, err, id, infl, infl_last;
  logic [7:0] len;
  logic [8:0] cnt;
  logic [MEM_ADDR_W-1:0] idx, ram_addr, aw_idx, ar_idx;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] mem [2**MEM_ADDR_W];
  logic both, aw_go, ar_go, aw_bad, ar_bad, w_hs, w_last, we, r_pop, rd_issue;
  logic [1:0] buf_cnt;
  logic unused_ok;
  assign aw_idx = axi_awaddr[MEM_ADDR_W+OFF-1:OFF];
  assign ar_idx = axi_araddr[MEM_ADDR_W+OFF-1:OFF];
  assign aw_bad = axi_awburst != BURST_INCR || axi_awsize != 3'(OFF);
  assign ar_bad = axi_arburst != BURST_INCR || axi_arsize != 3'(OFF);
  assign unused_ok = ^{axi_awlock, axi_awcache, axi_awprot, axi_awqos, axi_arlock, axi_arcache,
                       axi_arprot, axi_arqos, axi_awaddr[ADDR_W-1:MEM_ADDR_W+OFF], axi_awaddr[OFF-1:0],
                       axi_araddr[ADDR_W-1:MEM_ADDR_W+OFF], axi_araddr[OFF-1:0]};
  assign axi_bid = id;
  assign axi_rid = id;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    both = axi_awvalid & axi_arvalid;
    axi_awready = state == IDLE && !(both && prio_rd);
    axi_arready = state == IDLE && !(both && !prio_rd);
    aw_go = axi_awvalid & axi_awready;
    ar_go = axi_arvalid & axi_arready;
    axi_wready = state == WRITE;
    w_hs = axi_wvalid & axi_wready;
    w_last = cnt == {1'b0, len};
    we = w_hs & !err;
    axi_bvalid = state == WRESP;
    axi_bresp = axi_bvalid && err ? RESP_SLVERR : RESP_OKAY;
    r_pop = axi_rvalid & axi_rready;
    // issue only if the word landing next cycle is sure to find a slot
    rd_issue = ar_go || (state == READ && cnt <= {1'b0, len} &&
               ({1'b0, buf_cnt} + {2'b0, infl} - {2'b0, r_pop}) <= 3'd1);
    ram_addr = ar_go ? ar_idx : idx;
    case (state)
      IDLE: state_nx = aw_go ? WRITE : ar_go ? READ : IDLE;
      WRITE: state_nx = w_hs && w_last ? WRESP : WRITE;
      WRESP: state_nx = axi_bready ? IDLE : WRESP;
      READ: state_nx = r_pop && axi_rlast ? IDLE : READ;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      prio_rd <= 1'b0;
      err <= 1'b0;
      id <= 1'b0;
      infl <= 1'b0;
      infl_last <= 1'b0;
      len <= '0;
      cnt <= '0;
      idx <= '0;
    end else begin
      infl <= rd_issue;
      if (aw_go || ar_go) begin
        prio_rd <= aw_go;
        id <= aw_go ? axi_awid : axi_arid;
        len <= aw_go ? axi_awlen : axi_arlen;
        err <= aw_go ? aw_bad : ar_bad;
      end
      if (aw_go) begin
        idx <= aw_idx;
        cnt <= '0;
      end
      if (w_hs) begin
        cnt <= cnt + 9'd1;
        idx <= idx + 1'b1;
        if (axi_wlast != w_last) err <= 1'b1;
      end
      if (rd_issue) begin
        idx <= ram_addr + 1'b1;
        cnt <= ar_go ? 9'd1 : cnt + 9'd1;
        infl_last <= ar_go ? axi_arlen == 8'd0 : cnt[7:0] == len;
      end
    end
  always_ff @(posedge clk) begin
    for (int i = 0; i < SW; i++)
      if (we && axi_wstrb[i]) mem[idx][i*8 +: 8] <= axi_wdata[i*8 +: 8];
    ram_q <= mem[ram_addr];
  end
  axi_resp_skid_buf #(.W(DATA_W + 3)) u_skid (
    .clk(clk),
    .rst(rst),
    .in_valid(infl),
    .in_data({err ? '0 : ram_q, err ? RESP_SLVERR : RESP_OKAY, infl_last}),
    .out_valid(axi_rvalid),
    .out_ready(axi_rready),
    .out_data({axi_rdata, axi_rresp, axi_rlast}),
    .count(buf_cnt)
  );
endmodule
